// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader and the i-cache write port it feeds.
package prog_loader_pkg;

  localparam int unsigned ADDR_W_DEF     = 19;
  localparam int unsigned DEPTH_DEF      = 1024;
  localparam int unsigned ARM_CYCLES_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ARM,
    ST_REL,
    ST_RUN,
    ST_ERR
  } state_t;

endpackage

// File: rtl/prog_loader.sv
// Streams instruction words into the core i-cache, then sequences core reset release and start.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF,
  parameter int unsigned ARM_CYCLES = ARM_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              go,
  input  logic              halt,
  input  logic              clear_err,
  input  logic [31:0]       s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [31:0]       i_instruction,
  output logic [ADDR_W-1:0] i_addr,
  output logic              i_wea,
  output logic              start,
  output logic              core_rst_n,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned ARM_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(DEPTH - 1);
  localparam logic [ARM_W-1:0] ARM_INIT  = ARM_W'(ARM_CYCLES - 1);

  state_t             state, state_nxt;
  logic [ARM_W-1:0]   arm_cnt, arm_nxt;
  logic [CNT_W-1:0]   words_nxt;
  logic [ADDR_W-1:0]  addr_nxt;
  logic [31:0]        instr_nxt;
  logic               wea_nxt;
  logic               ready_nxt;
  logic               start_nxt;
  logic               core_rst_n_nxt;
  logic               busy_nxt;
  logic               err_nxt;
  logic               handshake;

  // Words are only offered/accepted while the registered ready is high (LOAD only).
  assign handshake = s_valid && s_ready;

  // Next-state and next-output logic; outputs are registered from the next state.
  always_comb begin
    state_nxt = state;
    arm_nxt   = arm_cnt;
    words_nxt = words_loaded;
    addr_nxt  = i_addr;
    instr_nxt = i_instruction;
    wea_nxt   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (load_req) begin
          state_nxt = ST_LOAD;
          words_nxt = '0;
        end else if (go && (words_loaded != '0)) begin
          state_nxt = ST_ARM;
          arm_nxt   = ARM_INIT;
        end
      end
      ST_LOAD: begin
        // The word counter doubles as the write address; a new load always starts at 0.
        if (handshake) begin
          wea_nxt   = 1'b1;
          addr_nxt  = ADDR_W'(words_loaded);
          instr_nxt = s_data;
          words_nxt = words_loaded + CNT_W'(1);
        end
        if (halt) begin
          state_nxt = ST_IDLE;
        end else if (handshake && s_last) begin
          state_nxt = ST_ARM;
          arm_nxt   = ARM_INIT;
        end else if (handshake && (words_loaded == LAST_ADDR)) begin
          state_nxt = ST_ERR;
        end
      end
      ST_ARM: begin
        if (arm_cnt == '0) begin
          state_nxt = ST_REL;
        end else begin
          arm_nxt = arm_cnt - ARM_W'(1);
        end
      end
      ST_REL: begin
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (halt) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ERR: begin
        if (clear_err) begin
          state_nxt = ST_IDLE;
          words_nxt = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    ready_nxt      = (state_nxt == ST_LOAD);
    start_nxt      = (state_nxt == ST_RUN);
    core_rst_n_nxt = (state_nxt == ST_REL) || (state_nxt == ST_RUN);
    busy_nxt       = (state_nxt != ST_IDLE);
    err_nxt        = (state_nxt == ST_ERR);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      arm_cnt       <= '0;
      words_loaded  <= '0;
      i_addr        <= '0;
      i_instruction <= '0;
      i_wea         <= 1'b0;
      s_ready       <= 1'b0;
      start         <= 1'b0;
      core_rst_n    <= 1'b0;
      busy          <= 1'b0;
      err           <= 1'b0;
    end else begin
      state         <= state_nxt;
      arm_cnt       <= arm_nxt;
      words_loaded  <= words_nxt;
      i_addr        <= addr_nxt;
      i_instruction <= instr_nxt;
      i_wea         <= wea_nxt;
      s_ready       <= ready_nxt;
      start         <= start_nxt;
      core_rst_n    <= core_rst_n_nxt;
      busy          <= busy_nxt;
      err           <= err_nxt;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: scenario table, hand-written corner sequences,
// and randomized loads checked against a transaction-level model of the load rules.
module tb_prog_loader;

  localparam int unsigned ADDR_W     = 19;
  localparam int unsigned DEPTH      = 8;
  localparam int unsigned ARM_CYCLES = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_req, go, halt, clear_err;
  logic [31:0]       s_data;
  logic              s_valid, s_last;
  logic              s_ready;
  logic [31:0]       i_instruction;
  logic [ADDR_W-1:0] i_addr;
  logic              i_wea;
  logic              start, core_rst_n, busy, err;
  logic [ADDR_W:0]   words_loaded;

  prog_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .ARM_CYCLES(ARM_CYCLES)) dut (
    .clk(clk), .rst(rst), .load_req(load_req), .go(go), .halt(halt), .clear_err(clear_err),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .i_instruction(i_instruction), .i_addr(i_addr), .i_wea(i_wea), .start(start),
    .core_rst_n(core_rst_n), .busy(busy), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n_words;
    int gap;
    bit has_last;
    int exp_writes;
    bit exp_err;
    int exp_words;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  wr_t         wr_q[$];
  logic [31:0] prog[16];
  vec_t        vecs[5];

  // Capture every i-cache write pulse seen on the port.
  always @(negedge clk) begin
    if (i_wea === 1'b1) wr_q.push_back('{i_addr, i_instruction});
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // sel: 0 load_req, 1 go, 2 halt, 3 clear_err. Returns in the cycle after sampling.
  task automatic pulse(input int sel);
    case (sel)
      0: load_req = 1'b1;
      1: go = 1'b1;
      2: halt = 1'b1;
      default: clear_err = 1'b1;
    endcase
    @(negedge clk);
    load_req = 1'b0; go = 1'b0; halt = 1'b0; clear_err = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input bit last, input int budget, output bit ok);
    s_data = d; s_last = last; s_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (s_ready === 1'b1) ok = 1'b1;
      @(negedge clk);
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  // gap < 0 picks a random idle gap (0..2 cycles) after each non-final word.
  task automatic load_stream(input int n, input int gap, input bit has_last, output int accepted);
    bit ok;
    bit stop;
    accepted = 0;
    stop = 1'b0;
    for (int i = 0; i < n && !stop; i++) begin
      send_word(prog[i], has_last && (i == n - 1), 8, ok);
      if (!ok) stop = 1'b1;
      else begin
        accepted++;
        if (i != n - 1) repeat ((gap < 0) ? $urandom_range(0, 2) : gap) @(negedge clk);
      end
    end
  endtask

  task automatic wait_start(output int n);
    n = 1;
    while (start !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic compare_writes(input string tag, input int exp_n);
    check({tag, "_write_count"}, 64'(wr_q.size()), 64'(exp_n));
    for (int i = 0; i < wr_q.size() && i < exp_n; i++) begin
      check({tag, "_addr"}, 64'(wr_q[i].addr), 64'(i));
      check({tag, "_data"}, 64'(wr_q[i].data), 64'(prog[i]));
    end
    wr_q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_s_ready"}, 64'(s_ready), 64'(0));
    check({tag, "_i_wea"}, 64'(i_wea), 64'(0));
    check({tag, "_i_addr"}, 64'(i_addr), 64'(0));
    check({tag, "_i_instruction"}, 64'(i_instruction), 64'(0));
    check({tag, "_start"}, 64'(start), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_err"}, 64'(err), 64'(0));
    check({tag, "_words_loaded"}, 64'(words_loaded), 64'(0));
    check({tag, "_core_rst_n"}, 64'(core_rst_n), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  acc, lat, len, exp_wr;
    bit  has_last, exp_err;

    rst = 1'b1; load_req = 1'b0; go = 1'b0; halt = 1'b0; clear_err = 1'b0;
    s_data = '0; s_valid = 1'b0; s_last = 1'b0;

    // Scenario table: {words, gap, last, writes, err, words_loaded}
    vecs[0] = '{5, 2, 1'b1, 5, 1'b0, 5};
    vecs[1] = '{9, 0, 1'b0, 8, 1'b1, 8};
    vecs[2] = '{8, 0, 1'b1, 8, 1'b0, 8};
    vecs[3] = '{1, 0, 1'b1, 1, 1'b0, 1};
    vecs[4] = '{3, 1, 1'b1, 3, 1'b0, 3};

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);

    // go with nothing loaded is ignored
    pulse(1);
    check("go_empty_busy", 64'(busy), 64'(0));
    repeat (4) @(negedge clk);
    check("go_empty_start", 64'(start), 64'(0));

    // Basic 4-word load
    prog[0] = 32'h0000_0013; prog[1] = 32'h0010_0093;
    prog[2] = 32'h0020_0113; prog[3] = 32'h0020_81B3;
    wr_q.delete();
    pulse(0);
    check("load_s_ready", 64'(s_ready), 64'(1));
    check("load_busy", 64'(busy), 64'(1));
    check("load_core_rst_n", 64'(core_rst_n), 64'(0));
    load_stream(4, 0, 1'b1, acc);
    check("basic_s_ready_drop", 64'(s_ready), 64'(0));
    wait_start(lat);
    check("basic_start_latency", 64'(lat), 64'(ARM_CYCLES + 2));
    check("basic_words_loaded", 64'(words_loaded), 64'(4));
    check("basic_core_rst_n", 64'(core_rst_n), 64'(1));
    compare_writes("basic", 4);

    // Halt in RUN, then re-run without reloading
    pulse(2);
    check("halt_start", 64'(start), 64'(0));
    check("halt_core_rst_n", 64'(core_rst_n), 64'(0));
    check("halt_busy", 64'(busy), 64'(0));
    pulse(1);
    wait_start(lat);
    check("rerun_start_latency", 64'(lat), 64'(ARM_CYCLES + 2));
    check("rerun_no_writes", 64'(wr_q.size()), 64'(0));

    // halt and load_req together in RUN: back to IDLE, no load
    halt = 1'b1; load_req = 1'b1;
    @(negedge clk);
    halt = 1'b0; load_req = 1'b0;
    check("halt_load_busy", 64'(busy), 64'(0));
    check("halt_load_s_ready", 64'(s_ready), 64'(0));
    repeat (2) @(negedge clk);
    check("halt_load_s_ready_later", 64'(s_ready), 64'(0));
    check("halt_load_words", 64'(words_loaded), 64'(4));

    // Table-driven load scenarios
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 16; i++) prog[i] = $urandom;
      wr_q.delete();
      pulse(0);
      load_stream(vecs[v].n_words, vecs[v].gap, vecs[v].has_last, acc);
      check($sformatf("vec%0d_accepted", v), 64'(acc), 64'(vecs[v].exp_writes));
      if (vecs[v].exp_err) begin
        check($sformatf("vec%0d_err", v), 64'(err), 64'(1));
        check($sformatf("vec%0d_s_ready", v), 64'(s_ready), 64'(0));
        check($sformatf("vec%0d_core_rst_n", v), 64'(core_rst_n), 64'(0));
        check($sformatf("vec%0d_words", v), 64'(words_loaded), 64'(vecs[v].exp_words));
        pulse(3);
        check($sformatf("vec%0d_clr_busy", v), 64'(busy), 64'(0));
        check($sformatf("vec%0d_clr_err", v), 64'(err), 64'(0));
        check($sformatf("vec%0d_clr_words", v), 64'(words_loaded), 64'(0));
      end else begin
        check($sformatf("vec%0d_s_ready_drop", v), 64'(s_ready), 64'(0));
        wait_start(lat);
        check($sformatf("vec%0d_start_latency", v), 64'(lat), 64'(ARM_CYCLES + 2));
        check($sformatf("vec%0d_words", v), 64'(words_loaded), 64'(vecs[v].exp_words));
        pulse(2);
      end
      compare_writes($sformatf("vec%0d", v), vecs[v].exp_writes);
    end

    // Randomized loads against the transaction-level model
    for (int r = 0; r < 25; r++) begin
      len = $urandom_range(1, 10);
      has_last = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 16; i++) prog[i] = $urandom;
      exp_wr  = (len < int'(DEPTH)) ? len : int'(DEPTH);
      exp_err = (len > int'(DEPTH)) || (!has_last && len >= int'(DEPTH));
      wr_q.delete();
      pulse(0);
      load_stream(len, -1, has_last, acc);
      check("rnd_accepted", 64'(acc), 64'(exp_wr));
      check("rnd_err", 64'(err), 64'(exp_err));
      if (exp_err) begin
        check("rnd_err_words", 64'(words_loaded), 64'(DEPTH));
        pulse(3);
        check("rnd_clr_words", 64'(words_loaded), 64'(0));
      end else if (has_last) begin
        wait_start(lat);
        check("rnd_start_latency", 64'(lat), 64'(ARM_CYCLES + 2));
        check("rnd_words", 64'(words_loaded), 64'(len));
        pulse(2);
        check("rnd_halt_start", 64'(start), 64'(0));
      end else begin
        check("rnd_still_loading", 64'(s_ready), 64'(1));
        pulse(2);
        check("rnd_halt_busy", 64'(busy), 64'(0));
        check("rnd_halt_words", 64'(words_loaded), 64'(len));
        pulse(1);
        wait_start(lat);
        check("rnd_go_latency", 64'(lat), 64'(ARM_CYCLES + 2));
        pulse(2);
      end
      compare_writes("rnd", exp_wr);
    end

    // Asynchronous reset in the middle of a load
    for (int i = 0; i < 16; i++) prog[i] = $urandom;
    pulse(0);
    load_stream(2, 0, 1'b0, acc);
    check("midload_words_before", 64'(words_loaded), 64'(2));
    s_valid = 1'b1; s_data = prog[2];
    #2 rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    @(negedge clk);
    rst = 1'b0; s_valid = 1'b0;
    wr_q.delete();
    pulse(1);
    check("post_rst_go_ignored", 64'(busy), 64'(0));
    repeat (3) @(negedge clk);
    check("post_rst_no_writes", 64'(wr_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
